// File: rtl/data_reg_mp_pkg.sv
// Shared types and helpers for the multi-read-port data register bank.
package dreg_pkg;

    // Sequencer states: zero-fill after reset, then normal access
    typedef enum logic [0:0] {
        DREG_INIT  = 1'b0,
        DREG_READY = 1'b1
    } dreg_state_e;

    localparam int unsigned DREG_MAX_RD = 4;
    // Widest data word the parity helper accepts; narrower words are zero-extended
    localparam int unsigned DREG_MAX_DW = 64;

    // Even parity over a zero-extended word (zero-extension does not change the result)
    function automatic logic dreg_parity(input logic [DREG_MAX_DW-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/data_reg_mp_if.sv
// Access bus of the data register bank: NUM_RD read ports, one write port, ready.
interface data_reg_mp_if #(
    parameter int unsigned DW     = 16,
    parameter int unsigned AW     = 7,
    parameter int unsigned NUM_RD = 2
);
    logic                   ready;
    logic [NUM_RD-1:0]      rd_en;
    logic [NUM_RD*AW-1:0]   rd_adr;
    logic [NUM_RD*DW-1:0]   rd_data;
    logic [NUM_RD-1:0]      rd_valid;
    logic [NUM_RD-1:0]      rd_perr;
    logic                   wr_en;
    logic [AW-1:0]          wr_adr;
    logic [DW-1:0]          wr_data;
    logic                   wr_perr_inj;

    modport master (
        input  ready, rd_data, rd_valid, rd_perr,
        output rd_en, rd_adr, wr_en, wr_adr, wr_data, wr_perr_inj
    );

    modport slave (
        output ready, rd_data, rd_valid, rd_perr,
        input  rd_en, rd_adr, wr_en, wr_adr, wr_data, wr_perr_inj
    );
endinterface

// File: rtl/data_reg_mp_rd_port.sv
// One registered read port: write-forwarding mux, data/valid register, parity check.
// Parity checking is present only when DREG_PARITY_EN is defined.
module dreg_rd_port
    import dreg_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned SW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_req,
    input  logic [SW-1:0] mem_word,
    input  logic          fwd_sel,
    input  logic [SW-1:0] wr_word,
    output logic [DW-1:0] data,
    output logic          valid,
    output logic          perr
);

    logic [SW-1:0] word_c;
    logic          chk_c;

    // Same-edge write to the read address wins over the stored word
    assign word_c = fwd_sel ? wr_word : mem_word;

`ifdef DREG_PARITY_EN
    assign chk_c = dreg_parity(DREG_MAX_DW'(word_c[DW-1:0])) ^ word_c[DW];
`else
    assign chk_c = 1'b0;
`endif

    // Register read result; data holds its last value when not reading
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
            perr  <= 1'b0;
        end else begin
            valid <= rd_req;
            perr  <= rd_req & chk_c;
            if (rd_req) begin
                data <= word_c[DW-1:0];
            end
        end
    end

endmodule

// File: rtl/data_reg_mp.sv
// Multi-read-port data register bank with hardware zero-fill after reset.
// Optional per-word parity storage and checking: define DREG_PARITY_EN.
module data_reg_mp
    import dreg_pkg::*;
#(
    parameter int unsigned DW     = 16,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned NUM_RD = 2
) (
    input  logic          clk,
    input  logic          rst,
    data_reg_mp_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
`ifdef DREG_PARITY_EN
    localparam int unsigned SW = DW + 1;
`else
    localparam int unsigned SW = DW;
`endif

    logic [SW-1:0] mem [DEPTH];
    dreg_state_e   state;
    logic [AW-1:0] fill_ptr;
    logic          ready_q;
    logic          wr_fire_c;
    logic [SW-1:0] wr_word_c;

    assign wr_fire_c = (state == DREG_READY) && bus.wr_en;
    assign bus.ready = ready_q;

`ifdef DREG_PARITY_EN
    assign wr_word_c = {dreg_parity(DREG_MAX_DW'(bus.wr_data)) ^ bus.wr_perr_inj, bus.wr_data};
`else
    logic unused_inj;
    assign wr_word_c  = bus.wr_data;
    assign unused_inj = bus.wr_perr_inj;
`endif

    // Zero-fill sequencer: one word per cycle, then hand over to normal access
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DREG_INIT;
            fill_ptr <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                DREG_INIT: begin
                    fill_ptr <= fill_ptr + 1'b1;
                    if (fill_ptr == AW'(DEPTH - 1)) begin
                        state   <= DREG_READY;
                        ready_q <= 1'b1;
                    end
                end
                DREG_READY: begin
                    state <= DREG_READY;
                end
                default: begin
                    state   <= DREG_INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage write: fill zeros during INIT, user writes once READY
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == DREG_INIT) begin
                mem[fill_ptr] <= '0;
            end else if (bus.wr_en) begin
                mem[bus.wr_adr] <= wr_word_c;
            end
        end
    end

    // One registered read port per requested port
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] adr_c;
        logic [SW-1:0] word_c;
        logic          fwd_c;
        logic          req_c;

        assign adr_c  = bus.rd_adr[p*AW +: AW];
        assign word_c = mem[adr_c];
        assign fwd_c  = wr_fire_c && (bus.wr_adr == adr_c);
        assign req_c  = bus.rd_en[p] && (state == DREG_READY);

        dreg_rd_port #(
            .DW (DW),
            .SW (SW)
        ) u_port (
            .clk      (clk),
            .rst      (rst),
            .rd_req   (req_c),
            .mem_word (word_c),
            .fwd_sel  (fwd_c),
            .wr_word  (wr_word_c),
            .data     (bus.rd_data[p*DW +: DW]),
            .valid    (bus.rd_valid[p]),
            .perr     (bus.rd_perr[p])
        );
    end

endmodule

// File: tb/tb_data_reg_mp.sv
// Self-checking bench for data_reg_mp (DW=16, DEPTH=128, NUM_RD=2).
module tb_data_reg_mp;

    localparam int unsigned DW     = 16;
    localparam int unsigned DEPTH  = 128;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned AW     = 7;
`ifdef DREG_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    data_reg_mp_if #(.DW(DW), .AW(AW), .NUM_RD(NUM_RD)) bus ();

    data_reg_mp #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: memory image, ready countdown and per-port expected outputs
    logic [DW-1:0]     m_mem [DEPTH];
    logic              m_par [DEPTH];
    logic              m_live = 1'b0;
    logic              m_ready;
    int                m_cnt;
    logic [DW-1:0]     m_data [NUM_RD];
    logic [NUM_RD-1:0] m_valid;
    logic [NUM_RD-1:0] m_perr;

    always @(posedge clk) begin
        if (rst) begin
            m_live  <= 1'b1;
            m_ready <= 1'b0;
            m_cnt   <= 0;
            m_valid <= '0;
            m_perr  <= '0;
            for (int p = 0; p < NUM_RD; p++) m_data[p] <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] <= '0;
                m_par[i] <= 1'b0;
            end
        end else if (!m_ready) begin
            m_cnt   <= m_cnt + 1;
            m_ready <= (m_cnt + 1 >= DEPTH);
            m_valid <= '0;
            m_perr  <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                logic [AW-1:0] a;
                logic [DW-1:0] d;
                logic          pb;
                a = bus.rd_adr[p*AW +: AW];
                if (bus.wr_en && bus.wr_adr == a) begin
                    d  = bus.wr_data;
                    pb = (^bus.wr_data) ^ bus.wr_perr_inj;
                end else begin
                    d  = m_mem[a];
                    pb = m_par[a];
                end
                m_valid[p] <= bus.rd_en[p];
                m_perr[p]  <= bus.rd_en[p] && PAR_EN && ((^d) ^ pb);
                if (bus.rd_en[p]) m_data[p] <= d;
            end
            if (bus.wr_en) begin
                m_mem[bus.wr_adr] <= bus.wr_data;
                m_par[bus.wr_adr] <= (^bus.wr_data) ^ bus.wr_perr_inj;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("ready", 32'(bus.ready), 32'(m_ready));
        for (int p = 0; p < NUM_RD; p++) begin
            chk($sformatf("rd_valid%0d", p), 32'(bus.rd_valid[p]), 32'(m_valid[p]));
            chk($sformatf("rd_data%0d", p), 32'(bus.rd_data[p*DW +: DW]), 32'(m_data[p]));
            chk($sformatf("rd_perr%0d", p), 32'(bus.rd_perr[p]), 32'(m_perr[p]));
        end
    endtask

    task automatic idle();
        bus.wr_en       = 1'b0;
        bus.wr_adr      = '0;
        bus.wr_data     = '0;
        bus.wr_perr_inj = 1'b0;
        bus.rd_en       = '0;
        bus.rd_adr      = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic inj);
        bus.wr_en = 1'b1; bus.wr_adr = a; bus.wr_data = d; bus.wr_perr_inj = inj;
        @(negedge clk);
        bus.wr_en = 1'b0; bus.wr_perr_inj = 1'b0;
    endtask

    task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] en);
        bus.rd_en = en; bus.rd_adr = {a1, a0};
        @(negedge clk);
        bus.rd_en = '0;
    endtask

    // Release reset and pin ready timing: low after 127 edges, high after 128
    task automatic release_and_fill(input string tag);
        rst = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            if (k == DEPTH - 1) chk({tag, "_ready_lo"}, 32'(bus.ready), 32'd0);
            if (k == DEPTH)     chk({tag, "_ready_hi"}, 32'(bus.ready), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        fork
            forever begin
                @(negedge clk);
                if (m_live) compare();
            end
        join_none

        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_valid", 32'(bus.rd_valid), 32'd0);

        // 1: fill timing, whole array reads zero
        release_and_fill("t1");
        for (int a = 0; a < DEPTH; a++) begin
            bus.rd_en  = 2'b11;
            bus.rd_adr = {AW'(DEPTH - 1 - a), AW'(a)};
            @(negedge clk);
        end
        bus.rd_en = '0;
        chk("t1_last_rd", 32'(bus.rd_data), 32'd0);

        // 2: write then dual read of same word
        wr(7'd5, 16'hA5A5, 1'b0);
        rd2(7'd5, 7'd5, 2'b11);
        chk("t2_data0", 32'(bus.rd_data[15:0]), 32'h0000_A5A5);
        chk("t2_data1", 32'(bus.rd_data[31:16]), 32'h0000_A5A5);
        chk("t2_valid", 32'(bus.rd_valid), 32'd3);
        @(negedge clk);
        chk("t2_hold_valid", 32'(bus.rd_valid), 32'd0);
        chk("t2_hold_data0", 32'(bus.rd_data[15:0]), 32'h0000_A5A5);

        // 3: same-edge write forwarding on port 0, port 1 reads another word
        bus.wr_en = 1'b1; bus.wr_adr = 7'd7; bus.wr_data = 16'h1234;
        bus.rd_en = 2'b11; bus.rd_adr = {7'd5, 7'd7};
        @(negedge clk);
        idle();
        chk("t3_fwd0", 32'(bus.rd_data[15:0]), 32'h0000_1234);
        chk("t3_data1", 32'(bus.rd_data[31:16]), 32'h0000_A5A5);

        // 4: reset mid-fill restarts fill and wipes earlier writes
        wr(7'd9, 16'hBEEF, 1'b0);
        rd2(7'd9, 7'd9, 2'b01);
        chk("t4_pre", 32'(bus.rd_data[15:0]), 32'h0000_BEEF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_midrst_ready", 32'(bus.ready), 32'd0);
        release_and_fill("t4");
        rd2(7'd9, 7'd9, 2'b11);
        chk("t4_wiped0", 32'(bus.rd_data[15:0]), 32'd0);
        chk("t4_wiped1", 32'(bus.rd_data[31:16]), 32'd0);

        // 5: accesses during INIT are ignored
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (k <= 20) begin
                bus.wr_en = 1'b1; bus.wr_adr = 7'd11; bus.wr_data = 16'hFFFF;
                bus.rd_en = 2'b11; bus.rd_adr = {7'd11, 7'd11};
            end else begin
                idle();
            end
            @(negedge clk);
            if (k == 20) chk("t5_init_valid", 32'(bus.rd_valid), 32'd0);
        end
        chk("t5_ready", 32'(bus.ready), 32'd1);
        rd2(7'd11, 7'd11, 2'b11);
        chk("t5_addr11", 32'(bus.rd_data), 32'd0);

        // Mixed traffic over a small address window for frequent collisions
        for (int k = 0; k < 300; k++) begin
            bus.wr_en       = 1'($urandom_range(0, 1));
            bus.wr_adr      = AW'($urandom_range(0, 15));
            bus.wr_data     = DW'($urandom);
            bus.wr_perr_inj = ($urandom_range(0, 7) == 0);
            bus.rd_en       = NUM_RD'($urandom_range(0, 3));
            bus.rd_adr      = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
            @(negedge clk);
        end
        idle();
        @(negedge clk);

`ifdef DREG_PARITY_EN
        // 6: injected parity error reported, cleared by clean rewrite, also on forwarded data
        wr(7'd3, 16'h0001, 1'b1);
        rd2(7'd3, 7'd3, 2'b11);
        chk("t6_perr_inj", 32'(bus.rd_perr), 32'd3);
        wr(7'd3, 16'h0001, 1'b0);
        rd2(7'd3, 7'd3, 2'b11);
        chk("t6_perr_clean", 32'(bus.rd_perr), 32'd0);
        bus.wr_en = 1'b1; bus.wr_adr = 7'd4; bus.wr_data = 16'h00F0; bus.wr_perr_inj = 1'b1;
        bus.rd_en = 2'b01; bus.rd_adr = {7'd0, 7'd4};
        @(negedge clk);
        idle();
        chk("t6_perr_fwd", 32'(bus.rd_perr), 32'd1);
`else
        // Without parity the inject input has no effect
        wr(7'd3, 16'h0001, 1'b1);
        rd2(7'd3, 7'd3, 2'b11);
        chk("t6_noparity_perr", 32'(bus.rd_perr), 32'd0);
        chk("t6_noparity_data", 32'(bus.rd_data[15:0]), 32'h0000_0001);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
